tnn_feature_framer: RTL and testbench

- Upstream stage of the approximate TNN classifier cores: five features, 3 bits each, one-bit class output.
- Accepts a stream of raw 8-bit feature samples over a valid/ready handshake.
- Quantizes each sample to 3 bits and assembles five consecutive samples into one frame.
- Presents the frame as registered, stable operands with a valid/ready handshake; double-buffered, so a new frame can fill while the previous one waits.

---
 rtl/tnn_feature_framer.sv | 145 ++++++++++++++
 tb/tb_tnn_feature_framer.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tnn_feature_framer.sv
// Collects five raw samples, quantizes each to Q_W bits and hands complete frames to the
// TNN classifier through a double-buffered valid/ready output register.
module tnn_feature_framer #(
    parameter int unsigned FEAT_W = 8,
    parameter int unsigned Q_W    = 3,
    parameter int unsigned N_FEAT = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [FEAT_W-1:0] s_data,
    input  logic              s_last,
    input  logic              flush,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [Q_W-1:0]    q_a,
    output logic [Q_W-1:0]    q_b,
    output logic [Q_W-1:0]    q_c,
    output logic [Q_W-1:0]    q_d,
    output logic [Q_W-1:0]    q_e,
    output logic              frame_err
);

    localparam logic [1:0] StFill    = 2'd0;
    localparam logic [1:0] StFull    = 2'd1;
    localparam logic [1:0] StDiscard = 2'd2;

    localparam int unsigned   CW       = $clog2(N_FEAT);
    localparam int unsigned   SHIFT    = FEAT_W - Q_W;
    localparam logic [FEAT_W:0] HALF   = {{FEAT_W{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic [FEAT_W:0] Q_MAX  = (FEAT_W + 1)'((2 ** Q_W) - 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(N_FEAT - 1);

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [Q_W-1:0]    slot_q [N_FEAT];
    logic [Q_W-1:0]    out_q  [N_FEAT];
    logic [Q_W-1:0]    frame  [N_FEAT];
    logic              m_valid_q;
    logic              err_q, err_d;
    logic              load, slot_we, clear_slots;
    logic              accept, out_free;
    logic [FEAT_W:0]   q_sum, q_shift;
    logic [Q_W-1:0]    q_cur;

    // Round-half-up with one guard bit so 0xFF does not wrap before saturation.
    always_comb begin
        q_sum   = {1'b0, s_data} + HALF;
        q_shift = q_sum >> SHIFT;
        q_cur   = (q_shift > Q_MAX) ? '1 : q_shift[Q_W-1:0];
    end

    assign s_ready  = !flush && (state_q != StFull);
    assign accept   = s_valid && s_ready;
    assign out_free = !m_valid_q || m_ready;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        err_d       = 1'b0;
        load        = 1'b0;
        slot_we     = 1'b0;
        clear_slots = 1'b0;
        for (int i = 0; i < int'(N_FEAT); i++) frame[i] = slot_q[i];

        if (flush) begin
            state_d     = StFill;
            count_d     = '0;
            clear_slots = 1'b1;
        end else begin
            case (state_q)
                StFill: begin
                    if (accept) begin
                        slot_we = 1'b1;
                        if (count_q == LAST_IDX) begin
                            count_d = '0;
                            if (s_last) begin
                                // Final sample bypasses the slot so the frame lands in one cycle.
                                frame[N_FEAT-1] = q_cur;
                                if (out_free) load = 1'b1;
                                else          state_d = StFull;
                            end else begin
                                err_d   = 1'b1;
                                state_d = StDiscard;
                            end
                        end else if (s_last) begin
                            err_d   = 1'b1;
                            count_d = '0;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                StFull: begin
                    if (out_free) begin
                        load    = 1'b1;
                        state_d = StFill;
                    end
                end
                StDiscard: begin
                    if (accept && s_last) state_d = StFill;
                end
                default: state_d = StFill;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StFill;
            count_q   <= '0;
            err_q     <= 1'b0;
            m_valid_q <= 1'b0;
            for (int i = 0; i < int'(N_FEAT); i++) begin
                slot_q[i] <= '0;
                out_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            if (clear_slots) begin
                for (int i = 0; i < int'(N_FEAT); i++) slot_q[i] <= '0;
            end else if (slot_we) begin
                slot_q[count_q] <= q_cur;
            end
            if (load) begin
                out_q     <= frame;
                m_valid_q <= 1'b1;
            end else if (m_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign m_valid   = m_valid_q;
    assign frame_err = err_q;
    assign q_a       = out_q[0];
    assign q_b       = out_q[1];
    assign q_c       = out_q[2];
    assign q_d       = out_q[3];
    assign q_e       = out_q[4];

endmodule

// File: tb/tb_tnn_feature_framer.sv
// Self-checking bench for tnn_feature_framer: directed scenarios plus random traffic, all
// compared against a frame-level reference model built from queues.
module tb_tnn_feature_framer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = 8'h00;
    logic       s_last = 1'b0;
    logic       flush = 1'b0;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [2:0] q_a, q_b, q_c, q_d, q_e;
    logic       frame_err;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [2:0] coll[$];
    bit         disc = 1'b0;
    bit         pend_v = 1'b0;
    logic [2:0] pend [5];
    bit         mv = 1'b0;
    logic [2:0] mo [5];
    bit         merr = 1'b0;

    tnn_feature_framer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .flush     (flush),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .q_a       (q_a),
        .q_b       (q_b),
        .q_c       (q_c),
        .q_d       (q_d),
        .q_e       (q_e),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] quant(input logic [7:0] d);
        int v;
        v = (int'(d) + 16) / 32;
        if (v > 7) v = 7;
        return 3'(v);
    endfunction

    function automatic logic [16:0] obs();
        return {m_valid, q_a, q_b, q_c, q_d, q_e, frame_err};
    endfunction

    function automatic logic [16:0] expv();
        return {mv, mo[0], mo[1], mo[2], mo[3], mo[4], merr};
    endfunction

    function automatic logic exp_sready();
        return !flush && !pend_v;
    endfunction

    task automatic model_step();
        bit         free, loaded, err;
        logic [2:0] nf [5];
        err = 1'b0;
        loaded = 1'b0;
        for (int i = 0; i < 5; i++) nf[i] = 3'd0;
        if (!rst_n) begin
            coll.delete();
            disc = 0; pend_v = 0; mv = 0; merr = 0;
            for (int i = 0; i < 5; i++) mo[i] = 3'd0;
            return;
        end
        free = !mv || m_ready;
        if (flush) begin
            coll.delete();
            disc = 0;
            pend_v = 0;
        end else if (pend_v) begin
            if (free) begin
                nf = pend;
                loaded = 1;
                pend_v = 0;
            end
        end else if (s_valid) begin
            if (disc) begin
                if (s_last) disc = 0;
            end else begin
                coll.push_back(quant(s_data));
                if (coll.size() == 5 && s_last) begin
                    for (int i = 0; i < 5; i++) nf[i] = coll[i];
                    if (free) loaded = 1;
                    else begin
                        pend = nf;
                        pend_v = 1;
                    end
                    coll.delete();
                end else if (s_last) begin
                    err = 1;
                    coll.delete();
                end else if (coll.size() == 5) begin
                    err = 1;
                    disc = 1;
                    coll.delete();
                end
            end
        end
        if (loaded) begin
            mo = nf;
            mv = 1;
        end else if (mv && m_ready) begin
            mv = 0;
        end
        merr = err;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l);
        s_valid = v;
        s_data  = d;
        s_last  = l;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        checks++;
        if (obs() !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want %h", obs(), 17'd0);
        end
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_s_ready: got %b want 1", s_ready);
        end
    endtask

    task automatic test_known_frame();
        logic [7:0] smp [5];
        smp = '{8'h00, 8'h10, 8'h80, 8'hEF, 8'hFF};
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, smp[i], i == 4);
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL known_model[%0d]: got %h want %h", i, obs(), expv());
            end
        end
        checks++;
        if (obs() !== {1'b1, 3'd0, 3'd1, 3'd4, 3'd7, 3'd7, 1'b0}) begin
            errors++;
            $display("FAIL known_const: got %h want %h", obs(),
                     {1'b1, 3'd0, 3'd1, 3'd4, 3'd7, 3'd7, 1'b0});
        end
        drive(1'b0, 8'h00, 1'b0);
        tick();
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL known_drain: got %b want 0", m_valid);
        end
    endtask

    task automatic test_backpressure();
        m_ready = 1'b0;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 5; i++) begin
                drive(1'b1, 8'($urandom), i == 4);
                tick();
                checks++;
                if (obs() !== expv()) begin
                    errors++;
                    $display("FAIL bp_fill[%0d,%0d]: got %h want %h", f, i, obs(), expv());
                end
            end
        end
        drive(1'b0, 8'h00, 1'b0);
        #1;
        checks++;
        if (s_ready !== 1'b0 || exp_sready() !== 1'b0) begin
            errors++;
            $display("FAIL bp_s_ready_full: got %b want 0", s_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got %h want %h", i, obs(), expv());
            end
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        checks++;
        if (obs() !== expv() || m_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_handover: got %h want %h", obs(), expv());
        end
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_s_ready_back: got %b want 1", s_ready);
        end
        m_ready = 1'b1;
        tick();
    endtask

    task automatic test_early_last();
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'($urandom), i == 2);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0);
        checks++;
        if (frame_err !== 1'b1 || m_valid !== 1'b0 || obs() !== expv()) begin
            errors++;
            $display("FAIL early_err_pulse: got %h want %h", obs(), expv());
        end
        tick();
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL early_err_end: got %b want 0", frame_err);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'($urandom), i == 4);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0);
        checks++;
        if (obs() !== expv() || m_valid !== 1'b1) begin
            errors++;
            $display("FAIL early_next_frame: got %h want %h", obs(), expv());
        end
        tick();
    endtask

    task automatic test_missing_last();
        int pulses = 0;
        m_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, 8'($urandom), i == 7 || i == 12);
            tick();
            if (frame_err === 1'b1) pulses++;
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL missing_step[%0d]: got %h want %h", i, obs(), expv());
            end
        end
        drive(1'b0, 8'h00, 1'b0);
        checks++;
        if (m_valid !== 1'b1) begin
            errors++;
            $display("FAIL missing_frame_out: got %b want 1", m_valid);
        end
        tick();
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL missing_pulse_count: got %0d want 1", pulses);
        end
    endtask

    task automatic test_flush();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'($urandom), i == 4);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 8'($urandom), 1'b0);
            tick();
        end
        drive(1'b1, 8'hFF, 1'b0);
        flush = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_s_ready: got %b want 0", s_ready);
        end
        tick();
        flush = 1'b0;
        checks++;
        if (obs() !== expv() || m_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_out_kept: got %h want %h", obs(), expv());
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'($urandom), i == 4);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0);
        m_ready = 1'b1;
        tick();
        checks++;
        if (obs() !== expv() || m_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_new_frame: got %h want %h", obs(), expv());
        end
        tick();
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 8'($urandom), i == 4);
            tick();
        end
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        tick();
        rst_n = 1'b1;
        checks++;
        if (obs() !== 17'd0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: got %h/%b want 0/1", obs(), s_ready);
        end
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'($urandom), i == 4);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0);
        checks++;
        if (obs() !== expv() || m_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_frame: got %h want %h", obs(), expv());
        end
        tick();
    endtask

    task automatic test_random();
        int  pos = 0;
        bit  l;
        for (int c = 0; c < 600; c++) begin
            l = (pos >= 4) ^ ($urandom_range(0, 11) == 0);
            drive($urandom_range(0, 3) != 0, 8'($urandom), l);
            flush   = ($urandom_range(0, 40) == 0);
            m_ready = ($urandom_range(0, 2) != 0);
            #1;
            checks++;
            if (s_ready !== exp_sready()) begin
                errors++;
                $display("FAIL rand_s_ready[%0d]: got %b want %b", c, s_ready, exp_sready());
            end
            if (flush) pos = 0;
            else if (s_valid && exp_sready()) pos = l ? 0 : pos + 1;
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL rand_out[%0d]: got %h want %h", c, obs(), expv());
            end
        end
        flush = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 5; i++) begin
            mo[i] = 3'd0;
            pend[i] = 3'd0;
        end
        #2;
        test_reset();
        test_known_frame();
        test_backpressure();
        test_early_last();
        test_missing_last();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
